// File: rtl/coproc32016_pkg.sv
// rtl/coproc32016_pkg.sv - shared types, limits and byte-merge helper for the 32016 co-processor memory ports
package coproc32016_pkg;

    localparam int LATENCY_MAX = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RMW_RD,
        ST_WRITE,
        ST_DONE
    } sram_state_e;

    // Byte-lane merge: enabled lanes take the new data, the rest keep the old word.
    function automatic logic [31:0] be_merge(input logic [3:0]  be,
                                             input logic [31:0] new_data,
                                             input logic [31:0] old_data);
        logic [31:0] merged;
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/io_sram_ctrl.sv
// rtl/io_sram_ctrl.sv - IO-bus to asynchronous 32-bit SRAM controller with read-modify-write byte writes
// Optional feature macro: IO_SRAM_POSTED_WRITE_EN (early acknowledge of full-word writes)
module io_sram_ctrl
    import coproc32016_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int AW      = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          io_rd,
    input  logic          io_wr,
    input  logic [AW+1:0] io_a,
    input  logic [3:0]    io_be,
    input  logic [31:0]   io_di,
    output logic [31:0]   io_q,
    output logic          io_ready,
    output logic          ram_cs_b,
    output logic          ram_oe_b,
    output logic          ram_wr_b,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_dout,
    output logic          ram_dout_oe,
    input  logic [31:0]   ram_din
);

`ifdef IO_SRAM_POSTED_WRITE_EN
    localparam bit POSTED_WR = 1'b1;
`else
    localparam bit POSTED_WR = 1'b0;
`endif

    localparam logic [2:0] LAT_LOAD = (LATENCY > LATENCY_MAX) ? 3'(LATENCY_MAX) : 3'(LATENCY);

    sram_state_e   state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          cs_b_q, cs_b_d;
    logic          oe_b_q, oe_b_d;
    logic          wr_b_q, wr_b_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   dout_q, dout_d;
    logic          dout_oe_q, dout_oe_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          posted_q, posted_d;

    logic          unused_a_lsb;
    assign unused_a_lsb = ^io_a[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cs_b_d    = cs_b_q;
        oe_b_d    = oe_b_q;
        wr_b_d    = wr_b_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        dout_oe_d = dout_oe_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        posted_d  = posted_q;

        case (state_q)
            ST_IDLE: begin
                // The ready guard keeps a request still held in its ready cycle from restarting.
                if (sel && !ready_q && (io_rd || io_wr)) begin
                    addr_d = io_a[AW+1:2];
                    cnt_d  = LAT_LOAD;
                    if (io_rd) begin
                        state_d = ST_READ;
                        cs_b_d  = 1'b0;
                        oe_b_d  = 1'b0;
                    end else if (io_be == 4'hF) begin
                        state_d   = ST_WRITE;
                        cs_b_d    = 1'b0;
                        wr_b_d    = 1'b0;
                        dout_d    = io_di;
                        dout_oe_d = 1'b1;
                        if (POSTED_WR) begin
                            ready_d  = 1'b1;
                            posted_d = 1'b1;
                        end
                    end else if (io_be == 4'h0) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RMW_RD;
                        cs_b_d  = 1'b0;
                        oe_b_d  = 1'b0;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = ram_din;
                    cs_b_d  = 1'b1;
                    oe_b_d  = 1'b1;
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RMW_RD: begin
                if (cnt_q == 3'd0) begin
                    dout_d    = be_merge(io_be, io_di, ram_din);
                    dout_oe_d = 1'b1;
                    oe_b_d    = 1'b1;
                    wr_b_d    = 1'b0;
                    cnt_d     = LAT_LOAD;
                    state_d   = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WRITE: begin
                // Output enable stays on through DONE so the data outlives the write strobe.
                if (cnt_q == 3'd0) begin
                    cs_b_d  = 1'b1;
                    wr_b_d  = 1'b1;
                    state_d = ST_DONE;
                    ready_d = !posted_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                dout_oe_d = 1'b0;
                posted_d  = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            cs_b_q    <= 1'b1;
            oe_b_q    <= 1'b1;
            wr_b_q    <= 1'b1;
            addr_q    <= '0;
            dout_q    <= 32'd0;
            dout_oe_q <= 1'b0;
            rdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            posted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cs_b_q    <= cs_b_d;
            oe_b_q    <= oe_b_d;
            wr_b_q    <= wr_b_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            dout_oe_q <= dout_oe_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            posted_q  <= posted_d;
        end
    end

    assign io_q        = rdata_q;
    assign io_ready    = ready_q;
    assign ram_cs_b    = cs_b_q;
    assign ram_oe_b    = oe_b_q;
    assign ram_wr_b    = wr_b_q;
    assign ram_addr    = addr_q;
    assign ram_dout    = dout_q;
    assign ram_dout_oe = dout_oe_q;

endmodule

// File: tb/tb_io_sram_ctrl.sv
// tb/tb_io_sram_ctrl.sv - scoreboard bench for io_sram_ctrl with an asynchronous SRAM model
module tb_io_sram_ctrl;

    localparam int AW  = 19;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic          io_rd;
    logic          io_wr;
    logic [AW+1:0] io_a;
    logic [3:0]    io_be;
    logic [31:0]   io_di;
    logic [31:0]   io_q;
    logic          io_ready;
    logic          ram_cs_b;
    logic          ram_oe_b;
    logic          ram_wr_b;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_dout;
    logic          ram_dout_oe;
    logic [31:0]   ram_din;

    always #5 clk = ~clk;

    io_sram_ctrl #(.LATENCY(LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .sel(sel), .io_rd(io_rd), .io_wr(io_wr),
        .io_a(io_a), .io_be(io_be), .io_di(io_di), .io_q(io_q), .io_ready(io_ready),
        .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b), .ram_wr_b(ram_wr_b),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe),
        .ram_din(ram_din)
    );

    logic [31:0] sram [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = 10'd0;
    logic [31:0] pre_val = 32'd0;

    always @(posedge clk) begin
        if (pre_en) sram[pre_idx] <= pre_val;
        else if (!ram_cs_b && !ram_wr_b) sram[ram_addr[9:0]] <= ram_dout;
    end
    assign ram_din = (!ram_cs_b && !ram_oe_b) ? sram[ram_addr[9:0]] : 32'h0BADF00D;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   ref_mem [0:1023];
    logic [31:0]   exp_q [$];
    int            last_rdy, last_rd_lo, last_wr_lo, last_oe_hi, last_nready;
    logic [AW-1:0] last_addr;

    task automatic drop_req();
        io_rd = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = 10'(idx); pre_val = v;
        ref_mem[idx] = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [AW+1:0] a,
                          input logic [3:0] be, input logic [31:0] di,
                          input logic hold, input int tail);
        logic [31:0] m;
        int          idx;
        int          cyc;
        logic        done;
        logic [31:0] exp;
        idx = int'(a[11:2]);
        if (rd) begin
            exp_q.push_back(ref_mem[idx]);
        end else if (wr) begin
            m = ref_mem[idx];
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = di[8*i +: 8];
            ref_mem[idx] = m;
        end
        last_rdy = 0; last_rd_lo = 0; last_wr_lo = 0; last_oe_hi = 0; last_nready = 0;
        @(negedge clk);
        sel = 1'b1; io_rd = rd; io_wr = wr; io_a = a; io_be = be; io_di = di;
        cyc = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) last_addr = ram_addr;
            if (!ram_cs_b && !ram_oe_b) last_rd_lo++;
            if (!ram_cs_b && !ram_wr_b) last_wr_lo++;
            if (ram_dout_oe) last_oe_hi++;
            if (io_ready) begin
                last_nready++;
                if (last_rdy == 0) begin
                    last_rdy = cyc;
                    if (rd) begin
                        exp = exp_q.pop_front();
                        n_checks++;
                        if (io_q !== exp) begin
                            n_errors++;
                            $display("FAIL read_data @%08h: got %08h want %08h", a, io_q, exp);
                        end
                    end
                    if (!hold) drop_req();
                end
            end
            if (hold && last_rdy != 0 && cyc == last_rdy + 1) drop_req();
            if (last_rdy != 0 && cyc >= last_rdy + tail) done = 1'b1;
            if (cyc >= 40) begin
                n_checks++; n_errors++;
                $display("FAIL ready_timeout @%08h: no io_ready within 40 cycles", a);
                exp_q.delete();
                drop_req();
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; drop_req(); io_a = '0; io_be = 4'h0; io_di = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (ram_cs_b !== 1'b1) begin n_errors++; $display("FAIL rst_cs_b: got %b want 1", ram_cs_b); end
        n_checks++; if (ram_oe_b !== 1'b1) begin n_errors++; $display("FAIL rst_oe_b: got %b want 1", ram_oe_b); end
        n_checks++; if (ram_wr_b !== 1'b1) begin n_errors++; $display("FAIL rst_wr_b: got %b want 1", ram_wr_b); end
        n_checks++; if (ram_dout_oe !== 1'b0) begin n_errors++; $display("FAIL rst_dout_oe: got %b want 0", ram_dout_oe); end
        n_checks++; if (io_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b want 0", io_ready); end
        n_checks++; if (io_q !== 32'd0) begin n_errors++; $display("FAIL rst_io_q: got %08h want 0", io_q); end
        n_checks++; if (ram_addr !== '0) begin n_errors++; $display("FAIL rst_addr: got %05h want 0", ram_addr); end
        n_checks++; if (ram_dout !== 32'd0) begin n_errors++; $display("FAIL rst_dout: got %08h want 0", ram_dout); end
        rst = 1'b0;
    endtask

    task automatic test_read();
        preload(32'h100, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 21'h400, 4'h0, 32'd0, 1'b0, 0);
        n_checks++; if (last_rdy != 3) begin n_errors++; $display("FAIL read_ready_cycle: got %0d want 3", last_rdy); end
        n_checks++; if (last_rd_lo != 2) begin n_errors++; $display("FAIL read_strobe_cycles: got %0d want 2", last_rd_lo); end
        n_checks++; if (last_addr !== 19'h100) begin n_errors++; $display("FAIL read_addr: got %05h want 00100", last_addr); end
        n_checks++; if (last_wr_lo != 0) begin n_errors++; $display("FAIL read_no_write: got %0d want 0", last_wr_lo); end
    endtask

    task automatic test_full_write();
        run_op(1'b0, 1'b1, 21'h404, 4'hF, 32'h12345678, 1'b0, 0);
`ifdef IO_SRAM_POSTED_WRITE_EN
        n_checks++; if (last_rdy != 1) begin n_errors++; $display("FAIL wr_ready_cycle: got %0d want 1", last_rdy); end
`else
        n_checks++; if (last_rdy != 3) begin n_errors++; $display("FAIL wr_ready_cycle: got %0d want 3", last_rdy); end
        n_checks++; if (last_wr_lo != 2) begin n_errors++; $display("FAIL wr_strobe_cycles: got %0d want 2", last_wr_lo); end
        n_checks++; if (last_oe_hi != 3) begin n_errors++; $display("FAIL wr_dout_oe_cycles: got %0d want 3", last_oe_hi); end
`endif
        repeat (4) @(negedge clk);
        n_checks++; if (ram_dout_oe !== 1'b0) begin n_errors++; $display("FAIL wr_oe_release: got %b want 0", ram_dout_oe); end
        n_checks++; if (sram[10'h101] !== 32'h12345678) begin n_errors++; $display("FAIL wr_sram_word: got %08h want 12345678", sram[10'h101]); end
        run_op(1'b1, 1'b0, 21'h404, 4'h0, 32'd0, 1'b0, 0);
    endtask

    task automatic test_rmw();
        preload(32'h102, 32'h11223344);
        run_op(1'b0, 1'b1, 21'h408, 4'b0100, 32'h00AA0000, 1'b0, 0);
        n_checks++; if (last_rdy != 5) begin n_errors++; $display("FAIL rmw_ready_cycle: got %0d want 5", last_rdy); end
        n_checks++; if (last_rd_lo != 2) begin n_errors++; $display("FAIL rmw_read_cycles: got %0d want 2", last_rd_lo); end
        n_checks++; if (last_wr_lo != 2) begin n_errors++; $display("FAIL rmw_write_cycles: got %0d want 2", last_wr_lo); end
        n_checks++; if (sram[10'h102] !== 32'h11AA3344) begin n_errors++; $display("FAIL rmw_sram_word: got %08h want 11aa3344", sram[10'h102]); end
        run_op(1'b1, 1'b0, 21'h408, 4'h0, 32'd0, 1'b0, 0);
    endtask

    task automatic test_be_zero();
        run_op(1'b0, 1'b1, 21'h408, 4'h0, 32'hFFFFFFFF, 1'b0, 2);
        n_checks++; if (last_rdy != 1) begin n_errors++; $display("FAIL be0_ready_cycle: got %0d want 1", last_rdy); end
        n_checks++; if (last_rd_lo + last_wr_lo != 0) begin n_errors++; $display("FAIL be0_no_sram: got %0d strobe cycles want 0", last_rd_lo + last_wr_lo); end
        n_checks++; if (sram[10'h102] !== 32'h11AA3344) begin n_errors++; $display("FAIL be0_sram_word: got %08h want 11aa3344", sram[10'h102]); end
    endtask

    task automatic test_rd_wr_both();
        run_op(1'b1, 1'b1, 21'h400, 4'hF, 32'h55555555, 1'b0, 0);
        n_checks++; if (last_wr_lo != 0) begin n_errors++; $display("FAIL both_no_write: got %0d want 0", last_wr_lo); end
        n_checks++; if (last_rdy != 3) begin n_errors++; $display("FAIL both_ready_cycle: got %0d want 3", last_rdy); end
    endtask

    task automatic test_sel_zero();
        int strobes;
        int readies;
        strobes = 0; readies = 0;
        @(negedge clk);
        sel = 1'b0; io_rd = 1'b1; io_a = 21'h400;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!ram_cs_b) strobes++;
            if (io_ready) readies++;
        end
        drop_req(); sel = 1'b1;
        n_checks++; if (strobes != 0) begin n_errors++; $display("FAIL sel0_strobes: got %0d want 0", strobes); end
        n_checks++; if (readies != 0) begin n_errors++; $display("FAIL sel0_ready: got %0d want 0", readies); end
    endtask

    task automatic test_held();
        run_op(1'b1, 1'b0, 21'h404, 4'h0, 32'd0, 1'b1, 6);
        n_checks++; if (last_nready != 1) begin n_errors++; $display("FAIL held_ready_pulses: got %0d want 1", last_nready); end
        n_checks++; if (last_rd_lo != 2) begin n_errors++; $display("FAIL held_strobe_cycles: got %0d want 2", last_rd_lo); end
    endtask

    task automatic test_reset_mid();
        int readies;
        readies = 0;
        @(negedge clk);
        sel = 1'b1; io_wr = 1'b1; io_a = 21'h40C; io_be = 4'hF; io_di = 32'hA5A5A5A5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({ram_cs_b, ram_oe_b, ram_wr_b} !== 3'b111) begin n_errors++; $display("FAIL midrst_strobes: got %b want 111", {ram_cs_b, ram_oe_b, ram_wr_b}); end
        n_checks++; if (ram_dout_oe !== 1'b0) begin n_errors++; $display("FAIL midrst_dout_oe: got %b want 0", ram_dout_oe); end
        n_checks++; if (io_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_ready: got %b want 0", io_ready); end
        rst = 1'b0; drop_req();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (io_ready) readies++;
        end
        n_checks++; if (readies != 0) begin n_errors++; $display("FAIL midrst_late_ready: got %0d want 0", readies); end
        run_op(1'b1, 1'b0, 21'h400, 4'h0, 32'd0, 1'b0, 0);
        n_checks++; if (last_rdy != 3) begin n_errors++; $display("FAIL midrst_read_cycle: got %0d want 3", last_rdy); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 1'b1, 21'h410, 4'hF, 32'hCAFEF00D, 1'b0, 0);
        run_op(1'b1, 1'b0, 21'h410, 4'h0, 32'd0, 1'b0, 0);
`ifdef IO_SRAM_POSTED_WRITE_EN
        n_checks++; if (last_rdy != 5) begin n_errors++; $display("FAIL b2b_read_cycle: got %0d want 5", last_rdy); end
`else
        n_checks++; if (last_rdy != 3) begin n_errors++; $display("FAIL b2b_read_cycle: got %0d want 3", last_rdy); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        test_reset();
        test_read();
        test_full_write();
        test_rmw();
        test_be_zero();
        test_rd_wr_both();
        test_sel_zero();
        test_held();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
